// File: rtl/tiny_synth_filter_pkg.sv
// Shared constants, FSM state type and helpers for the EWMA channel scheduler.
package tiny_synth_filter_pkg;

  // Gain is alpha / 2**EWMA_SHIFT.
  localparam int EWMA_SHIFT = 8;

  // Sequencer states of the time-multiplexed filter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  // Offset-binary midscale code for a given sample width.
  function automatic int midscale(input int data_w);
    return 32'sd1 << (data_w - 32'sd1);
  endfunction

endpackage

// File: rtl/ewma_step.sv
// Single EWMA update split into its two pipeline halves:
//   multiply half : prod = ((s_in - s_prev) * alpha) >>> EWMA_SHIFT
//   add half      : sum  = prod_reg + s_prev (low DATA_W bits, wrapping)
// The caller registers prod between the halves.
module ewma_step
  import tiny_synth_filter_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int ALPHA_W = 9
) (
  input  logic signed [DATA_W-1:0]  s_in,
  input  logic signed [DATA_W-1:0]  s_prev,
  input  logic signed [ALPHA_W-1:0] alpha,
  input  logic signed [DATA_W:0]    prod_reg,
  output logic signed [DATA_W:0]    prod,
  output logic        [DATA_W-1:0]  sum_lo
);

  // Full product width: the product of a (DATA_W+1)-bit and ALPHA_W-bit signed value.
  localparam int PW = DATA_W + 1 + ALPHA_W;

  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   mult;
  logic signed [PW-1:0]   shifted;
  logic        [DATA_W:0] sum_full;
  logic                   unused_bits;

  // Combinational datapath for both halves of the update.
  always_comb begin
    diff     = {s_in[DATA_W-1], s_in} - {s_prev[DATA_W-1], s_prev};
    mult     = $signed({{ALPHA_W{diff[DATA_W]}}, diff}) *
               $signed({{(DATA_W + 1){alpha[ALPHA_W-1]}}, alpha});
    // Arithmetic shift floors toward minus infinity for negative differences.
    shifted  = mult >>> EWMA_SHIFT;
    prod     = shifted[DATA_W:0];
    sum_full = prod_reg + {s_prev[DATA_W-1], s_prev};
    sum_lo   = sum_full[DATA_W-1:0];
  end

  // Discarded high bits: the result deliberately wraps to DATA_W bits.
  assign unused_bits = ^{shifted[PW-1:DATA_W+1], sum_full[DATA_W]};

endmodule

// File: rtl/ewma_channel_scheduler.sv
// Time-multiplexed multi-channel EWMA low-pass filter. One shared ewma_step
// serves all channels in round-robin order once per sample period; the output
// bank is refreshed for all channels at once together with a dout_valid pulse.
module ewma_channel_scheduler
  import tiny_synth_filter_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int ALPHA_W = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_strobe,
  input  logic [NUM_CH*DATA_W-1:0]    din,
  input  logic [NUM_CH*ALPHA_W-1:0]   alpha,
  output logic [NUM_CH*DATA_W-1:0]    dout,
  output logic                        dout_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_W-1:0]      MSB_MASK = DATA_W'(midscale(DATA_W));
  localparam logic [NUM_CH*DATA_W-1:0] MID_BANK = {NUM_CH{MSB_MASK}};
  localparam logic [CH_W-1:0]        LAST_CH  = CH_W'(NUM_CH - 1);

  fsm_state_e                  fsm_q, fsm_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [NUM_CH*DATA_W-1:0]    din_snap_q, din_snap_d;
  logic [NUM_CH*ALPHA_W-1:0]   alpha_snap_q, alpha_snap_d;
  logic [NUM_CH*DATA_W-1:0]    bank_q, bank_d;
  logic [NUM_CH*DATA_W-1:0]    dout_q, dout_d;
  logic signed [DATA_W:0]      prod_q, prod_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;

  logic signed [DATA_W-1:0]    s_in_s;
  logic signed [DATA_W-1:0]    s_prev_s;
  logic signed [ALPHA_W-1:0]   alpha_s;
  logic signed [DATA_W:0]      step_prod_s;
  logic        [DATA_W-1:0]    step_sum_s;

  // Select the current channel's operands and convert offset-binary to signed.
  always_comb begin
    s_in_s   = $signed(din_snap_q[ch_q*DATA_W +: DATA_W] ^ MSB_MASK);
    s_prev_s = $signed(bank_q[ch_q*DATA_W +: DATA_W] ^ MSB_MASK);
    alpha_s  = $signed(alpha_snap_q[ch_q*ALPHA_W +: ALPHA_W]);
  end

  ewma_step #(
    .DATA_W  (DATA_W),
    .ALPHA_W (ALPHA_W)
  ) u_step (
    .s_in     (s_in_s),
    .s_prev   (s_prev_s),
    .alpha    (alpha_s),
    .prod_reg (prod_q),
    .prod     (step_prod_s),
    .sum_lo   (step_sum_s)
  );

  // Sequencer: snapshot on strobe, MUL/ACC per channel, then publish the bank.
  always_comb begin
    fsm_d        = fsm_q;
    ch_d         = ch_q;
    din_snap_d   = din_snap_q;
    alpha_snap_d = alpha_snap_q;
    bank_d       = bank_q;
    dout_d       = dout_q;
    prod_d       = prod_q;
    valid_d      = 1'b0;

    case (fsm_q)
      ST_IDLE: begin
        if (sample_strobe) begin
          din_snap_d   = din;
          alpha_snap_d = alpha;
          ch_d         = '0;
          fsm_d        = ST_MUL;
        end else begin
          fsm_d        = ST_IDLE;
        end
      end
      ST_MUL: begin
        prod_d = step_prod_s;
        fsm_d  = ST_ACC;
      end
      ST_ACC: begin
        bank_d[ch_q*DATA_W +: DATA_W] = step_sum_s ^ MSB_MASK;
        if (ch_q == LAST_CH) begin
          // Publish the whole bank (including this channel's new value) so
          // dout and dout_valid are both visible during the DONE cycle.
          dout_d  = bank_d;
          valid_d = 1'b1;
          fsm_d   = ST_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          fsm_d   = ST_MUL;
        end
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // Status flags: sticky overrun on a strobe outside IDLE, busy follows the next state.
  always_comb begin
    if (sample_strobe && (fsm_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    busy_d = (fsm_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      ch_q         <= '0;
      din_snap_q   <= '0;
      alpha_snap_q <= '0;
      bank_q       <= MID_BANK;
      dout_q       <= MID_BANK;
      prod_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      ch_q         <= ch_d;
      din_snap_q   <= din_snap_d;
      alpha_snap_q <= alpha_snap_d;
      bank_q       <= bank_d;
      dout_q       <= dout_d;
      prod_q       <= prod_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ewma_channel_scheduler.sv
// Scoreboard bench for ewma_channel_scheduler: the driver computes each
// period's expected bank with an arithmetic reference model and queues it;
// a monitor pops and compares on every dout_valid pulse and checks that dout
// holds steady between pulses.
module tb_ewma_channel_scheduler;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 12;
  localparam int ALPHA_W = 9;
  localparam int MID     = 2048;
  localparam int LAT     = 2 * NUM_CH + 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       sample_strobe = 1'b0;
  logic [NUM_CH*DATA_W-1:0]   din = '0;
  logic [NUM_CH*ALPHA_W-1:0]  alpha = '0;
  logic [NUM_CH*DATA_W-1:0]   dout;
  logic                       dout_valid;
  logic                       busy;
  logic                       overrun;

  ewma_channel_scheduler #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .ALPHA_W (ALPHA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .din           (din),
    .alpha         (alpha),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int                        model_st [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]  exp_q [$];
  logic [NUM_CH*DATA_W-1:0]  last_exp = {NUM_CH{12'd2048}};
  logic [NUM_CH*DATA_W-1:0]  mon_e;
  logic [NUM_CH*DATA_W-1:0]  chg_din;
  logic [NUM_CH*ALPHA_W-1:0] chg_alpha;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // floor(x / 256) for any sign of x.
  function automatic int floor_div256(input int x);
    int q;
    q = x / 256;
    if ((x % 256) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  // Reference: new = old + floor((in - old) * alpha / 256), modulo 4096.
  function automatic int ref_next(input int st, input int d, input int a9);
    int a;
    int v;
    a = (a9 >= 256) ? a9 - 512 : a9;
    v = st + floor_div256((d - st) * a);
    return ((v % 4096) + 4096) % 4096;
  endfunction

  // Monitor: scoreboard compare on dout_valid, stability check otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_exp = {NUM_CH{12'd2048}};
      end else if (mon_en) begin
        if (dout_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dout_valid actual=1 expected=0");
          end else begin
            mon_e = exp_q.pop_front();
            for (int k = 0; k < NUM_CH; k++)
              check($sformatf("dout%0d", k), int'(dout[k*DATA_W +: DATA_W]),
                    int'(mon_e[k*DATA_W +: DATA_W]));
            last_exp = mon_e;
          end
        end else begin
          for (int k = 0; k < NUM_CH; k++)
            check($sformatf("dout%0d_stable", k), int'(dout[k*DATA_W +: DATA_W]),
                  int'(last_exp[k*DATA_W +: DATA_W]));
        end
      end
    end
  end

  // mode: 0 normal, 4 strobes at cycles 3 and LAT, 5 reset at cycle 5, 6 input change at cycle 2.
  task automatic run_period(input logic [NUM_CH*DATA_W-1:0] dv,
                            input logic [NUM_CH*ALPHA_W-1:0] av, input int mode);
    int n;
    bit got;
    bit aborted;
    logic [NUM_CH*DATA_W-1:0] e;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_before_strobe", int'(busy), 0);
    @(posedge clk); #1;
    din = dv;
    alpha = av;
    sample_strobe = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      model_st[k] = ref_next(model_st[k], int'(dv[k*DATA_W +: DATA_W]),
                             int'(av[k*ALPHA_W +: ALPHA_W]));
      e[k*DATA_W +: DATA_W] = model_st[k][DATA_W-1:0];
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    n = 0;
    got = 1'b0;
    aborted = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (dout_valid) got = 1'b1;
      if (mode == 4 && (n == 3 || n == LAT)) begin #1; sample_strobe = 1'b1; end
      if (mode == 4 && n == 4) begin #1; sample_strobe = 1'b0; end
      if (mode == 6 && n == 2) begin #1; din = chg_din; alpha = chg_alpha; end
      if (mode == 5 && n == 5) begin
        #1; rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        for (int k = 0; k < NUM_CH; k++) model_st[k] = MID;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_overrun", int'(overrun), 0);
      check("abort_valid", int'(dout_valid), 0);
      for (int k = 0; k < NUM_CH; k++)
        check($sformatf("abort_dout%0d", k), int'(dout[k*DATA_W +: DATA_W]), MID);
    end else begin
      check("latency", n, LAT);
      if (mode == 4) begin
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        check("done_strobe_ignored_busy", int'(busy), 0);
      end
      @(negedge clk);
      check("valid_one_cycle", int'(dout_valid), 0);
    end
  endtask

  // Stimulus.
  initial begin
    logic [NUM_CH*DATA_W-1:0]  dv;
    logic [NUM_CH*ALPHA_W-1:0] av;
    for (int k = 0; k < NUM_CH; k++) model_st[k] = MID;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(dout_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("reset_dout%0d", k), int'(dout[k*DATA_W +: DATA_W]), MID);
    #1 mon_en = 1'b1;

    // All channels at 2047, alpha one half.
    dv = {NUM_CH{12'd2047}};
    av = {NUM_CH{9'd128}};
    run_period(dv, av, 0);
    check("t1_dout3", int'(dout[3*DATA_W +: DATA_W]), 2047);

    // ch0 steps toward full scale, ch1 held with alpha 0.
    dv = {12'd2047, 12'd2047, 12'd100, 12'd4095};
    av = {9'd128, 9'd128, 9'd0, 9'd128};
    run_period(dv, av, 0);
    check("t2_dout0_first", int'(dout[0 +: DATA_W]), 3071);
    dv = {12'd2047, 12'd0, 12'd100, 12'd4095};
    run_period(dv, av, 0);
    check("t2_dout0_second", int'(dout[0 +: DATA_W]), 3583);
    check("t2_dout1_hold", int'(dout[DATA_W +: DATA_W]), 2047);
    check("t3_dout2_floor", int'(dout[2*DATA_W +: DATA_W]), 1023);

    // Strobes while busy and during DONE.
    check("overrun_clear_before", int'(overrun), 0);
    for (int k = 0; k < NUM_CH; k++) begin
      dv[k*DATA_W +: DATA_W] = 12'($urandom_range(4095, 0));
      av[k*ALPHA_W +: ALPHA_W] = 9'($urandom_range(255, 0));
    end
    run_period(dv, av, 4);
    check("overrun_set", int'(overrun), 1);
    run_period(dv, av, 0);
    check("overrun_sticky", int'(overrun), 1);

    // Reset mid-period, then a fresh run must match the first one.
    run_period(dv, av, 5);
    dv = {NUM_CH{12'd2047}};
    av = {NUM_CH{9'd128}};
    run_period(dv, av, 0);
    check("t5_fresh_dout0", int'(dout[0 +: DATA_W]), 2047);

    // Input change during a period only applies from the next strobe.
    for (int k = 0; k < NUM_CH; k++) begin
      dv[k*DATA_W +: DATA_W] = 12'($urandom_range(4095, 0));
      av[k*ALPHA_W +: ALPHA_W] = 9'($urandom_range(255, 0));
      chg_din[k*DATA_W +: DATA_W] = 12'($urandom_range(4095, 0));
      chg_alpha[k*ALPHA_W +: ALPHA_W] = 9'($urandom_range(255, 1));
    end
    run_period(dv, av, 6);
    run_period(chg_din, chg_alpha, 0);

    // Randomized periods.
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        dv[k*DATA_W +: DATA_W] = 12'($urandom_range(4095, 0));
        av[k*ALPHA_W +: ALPHA_W] = 9'($urandom_range(255, 0));
      end
      run_period(dv, av, 0);
    end

    // Negative alpha: result wraps modulo the sample width.
    for (int k = 0; k < NUM_CH; k++)
      dv[k*DATA_W +: DATA_W] = 12'($urandom_range(4095, 0));
    av = {NUM_CH{9'h100}};
    run_period(dv, av, 0);
    av = {NUM_CH{9'd64}};
    run_period(dv, av, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
